// File: rtl/vga_cell_renderer.sv
// Renders the Game-of-Life grid onto VGA: maps each visible pixel to its cell,
// fetches the cell state from the synchronous grid memory and emits RGB and syncs.
module vga_cell_renderer #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          CELL_SHIFT = 3,
    parameter int          GRID_W     = H_ACTIVE >> CELL_SHIFT,
    parameter int          GRID_H     = V_ACTIVE >> CELL_SHIFT,
    parameter int          ADDR_W     = $clog2(GRID_W * GRID_H),
    parameter logic [11:0] ALIVE_RGB  = 12'hFFF,
    parameter logic [11:0] DEAD_RGB   = 12'h000,
    parameter logic [11:0] GRID_RGB   = 12'h333,
    parameter bit          GRID_EN    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_draw_active,
    input  logic [$clog2(H_ACTIVE)-1:0] i_active_x,
    input  logic [$clog2(V_ACTIVE)-1:0] i_active_y,
    input  logic                        i_h_sync,
    input  logic                        i_v_sync,
    output logic                        o_rd_en,
    output logic [ADDR_W-1:0]           o_rd_addr,
    input  logic                        i_rd_data,
    output logic [3:0]                  o_vga_r,
    output logic [3:0]                  o_vga_g,
    output logic [3:0]                  o_vga_b,
    output logic                        o_h_sync,
    output logic                        o_v_sync,
    output logic                        o_frame_done
);

    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);

    localparam logic [X_W-1:0]    X_END     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_END     = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] GRID_W_A  = ADDR_W'(GRID_W);

    // Stage 1: address/read request plus per-pixel flags
    logic              rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              valid1_q,  valid1_d;
    logic              grid1_q,   grid1_d;
    logic              last1_q,   last1_d;
    logic              hs1_q,     hs1_d;
    logic              vs1_q,     vs1_d;

    // Stage 2: flags aligned with the memory read data
    logic              valid2_q,  valid2_d;
    logic              grid2_q,   grid2_d;
    logic              hs2_q,     hs2_d;
    logic              vs2_q,     vs2_d;
    logic              done2_q,   done2_d;

    logic              in_range;
    logic [ADDR_W-1:0] pix_addr;
    logic [11:0]       colour;

    always_comb begin
        in_range = i_draw_active && (i_active_x < X_END) && (i_active_y < Y_END);
        // Both operands are widened to ADDR_W so the row product never truncates
        pix_addr = ADDR_W'(i_active_y >> CELL_SHIFT) * GRID_W_A
                 + ADDR_W'(i_active_x >> CELL_SHIFT);

        rd_en_d   = in_range;
        rd_addr_d = in_range ? pix_addr : rd_addr_q;
        valid1_d  = in_range;
        grid1_d   = GRID_EN && ((i_active_x[CELL_SHIFT-1:0] == '0) ||
                                (i_active_y[CELL_SHIFT-1:0] == '0));
        last1_d   = in_range && (i_active_x == X_LAST) && (i_active_y == Y_LAST);
        hs1_d     = i_h_sync;
        vs1_d     = i_v_sync;

        valid2_d  = valid1_q;
        grid2_d   = grid1_q;
        hs2_d     = hs1_q;
        vs2_d     = vs1_q;
        done2_d   = last1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid1_q  <= 1'b0;
            grid1_q   <= 1'b0;
            last1_q   <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            valid2_q  <= 1'b0;
            grid2_q   <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            done2_q   <= 1'b0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid1_q  <= valid1_d;
            grid1_q   <= grid1_d;
            last1_q   <= last1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            valid2_q  <= valid2_d;
            grid2_q   <= grid2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            done2_q   <= done2_d;
        end
    end

    // The RAM output is already a register, so colour is a mux over stage-2
    // flops and the read data; this keeps total latency at two edges.
    always_comb begin
        colour = 12'h000;
        if (valid2_q) begin
            if (grid2_q)        colour = GRID_RGB;
            else if (i_rd_data) colour = ALIVE_RGB;
            else                colour = DEAD_RGB;
        end
    end

    assign o_rd_en      = rd_en_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_vga_r      = colour[11:8];
    assign o_vga_g      = colour[7:4];
    assign o_vga_b      = colour[3:0];
    assign o_h_sync     = hs2_q;
    assign o_v_sync     = vs2_q;
    assign o_frame_done = done2_q;

endmodule
